crc32_stream: RTL and testbench
===============================

Name: crc32_stream

Overview:
Parametrised Ethernet CRC-32 engine for the gigabit MAC datapath. It is the multi-lane successor of the single-byte CRC32 block. It accepts a byte-lane stream with valid/ready/keep/last, processes DATA_BYTES bytes per clock, and produces a per-frame FCS. It also supports a frame-check mode that verifies a received FCS against the CRC-32 magic residue. A result handshake holds the output until the consumer takes it, and a saturating byte counter is reported with each result.

Parameters:
DATA_BYTES, 4, byte lanes per beat; legal values 1, 2, 4, 8.
CNT_WIDTH, 16, width of the frame byte counter.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
s_valid  input  1  input beat valid
s_ready  output  1  input beat accepted when s_valid & s_ready
s_data  input  8*DATA_BYTES  lane 0 = s_data[7:0] = first byte on wire
s_keep  input  DATA_BYTES  lane enables; examined only on last beat; contiguous from lane 0
s_last  input  1  final beat of frame
chk_mode  input  1  0 = generate, 1 = check; sampled on first beat of frame
crc_valid  output  1  result available
crc_ready  input  1  result consumed when crc_valid & crc_ready
crc_out  output  32  FCS = ~bitreverse(lfsr); transmit crc_out[7:0] first
crc_err  output  1  check mode: residue mismatch; 0 in generate mode
byte_cnt  output  CNT_WIDTH  bytes in frame, saturating at all-ones

Behaviour:
- Polynomial: 0x04C11DB7, non-reflected LFSR.
  - Each byte is bit-reversed before entry.
  - LFSR initial value is 0xFFFFFFFF.
  - Lanes are applied in order 0..n-1 within one cycle as a combinational cascade of the 8-bit update.
- Reset values: LFSR = 0xFFFFFFFF, state = IDLE, s_ready = 1, crc_valid = 0, crc_out = 0, crc_err = 0, byte_cnt = 0.
- State IDLE: s_ready = 1.
  - Accepted beat with s_last = 0 -> BUSY.
  - Accepted beat with s_last = 1 -> RESULT.
  - The first accepted beat latches chk_mode.
- State BUSY: s_ready = 1.
  - Every accepted beat updates the LFSR with all lanes and adds DATA_BYTES to the counter.
  - Accepted beat with s_last = 1 -> RESULT.
- Last beat: only lanes with s_keep = 1 update the LFSR and the counter.
  - s_keep = 0 on the last beat is legal: no bytes are applied.
  - Non-contiguous keep is illegal; the bench shall not drive it.
- State RESULT: entered on the clock after the last beat (latency 1 cycle).
  - crc_valid = 1; crc_out, crc_err and byte_cnt are registered and held stable.
  - s_ready = 0.
  - On crc_valid & crc_ready: the LFSR is reinitialised to 0xFFFFFFFF, the counter is cleared, and the state goes to IDLE the next cycle. crc_valid drops the same edge.
- Check mode: crc_err = (LFSR != 0xC704DD7B) after the FCS bytes are included in the stream.
- byte_cnt stops at 2^CNT_WIDTH-1 and does not wrap.
- s_valid low while in IDLE or BUSY is an idle cycle: no state change.
- A reset asserted mid-frame or mid-RESULT discards the frame and returns immediately to reset values.

Optional Feature:
CRC32_STREAM_PIPE_EN
- Defined: an input register stage (data, keep, last, accepted flag) is inserted before the LFSR update to relieve the DATA_BYTES=8 cascade timing.
  - Result latency from the last beat becomes 2 cycles.
  - s_ready is also held 0 on the cycle the registered last beat is processed.
  - The result handshake is unchanged.
- Undefined: single-stage path as described above, latency 1.

Test Plan:
- DATA_BYTES=1, generate mode, bytes "123456789" (0x31..0x39), last on 0x39 -> crc_valid 1 cycle later, crc_out = 0xCBF43926, byte_cnt = 9, crc_err = 0.
- DATA_BYTES=4: beats "1234", "5678", "9" with keep = 0x1 and last -> crc_out = 0xCBF43926, byte_cnt = 9.
- Check mode, DATA_BYTES=4: "123456789" then 0x26, 0x39, 0xF4, 0xCB across beats -> crc_err = 0, byte_cnt = 13. Flip 0x35 to 0x36 -> crc_err = 1.
- Backpressure: hold crc_ready = 0 for 3 cycles with s_valid = 1 -> s_ready = 0 and outputs stable throughout. Assert crc_ready -> next frame accepted, and its CRC is independent of the previous frame.
- Empty last beat: "1234" with last = 0, then keep = 0 and last = 1 -> crc_out = CRC("1234") = 0x9BE3E0A3, byte_cnt = 4.
- Reset: rst_n low mid-frame after 5 bytes, then the full "123456789" -> crc_out = 0xCBF43926. CNT_WIDTH=4 with 20 bytes -> byte_cnt = 15.

Source files
------------

// File: rtl/crc32_stream.sv
// crc32_stream: multi-lane Ethernet CRC-32 generator/checker, valid/ready byte-lane input, held result output.
// Optional define CRC32_STREAM_PIPE_EN adds an input register stage before the LFSR update (result latency 2).
module crc32_stream #(
    parameter int DATA_BYTES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [8*DATA_BYTES-1:0] s_data,
    input  logic [DATA_BYTES-1:0]   s_keep,
    input  logic                    s_last,
    input  logic                    chk_mode,
    output logic                    crc_valid,
    input  logic                    crc_ready,
    output logic [31:0]             crc_out,
    output logic                    crc_err,
    output logic [CNT_WIDTH-1:0]    byte_cnt
);
    localparam logic [31:0] POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE = 32'hC704_DD7B;

    typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;

    state_t               state_q, state_d;
    logic [31:0]          lfsr_q, lfsr_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [31:0]          crc_out_q, crc_out_d;
    logic                 crc_err_q, crc_err_d;

    logic                    accept;
    logic [DATA_BYTES-1:0]   in_en;
    logic                    upd_valid, upd_last, upd_mode;
    logic [8*DATA_BYTES-1:0] upd_data;
    logic [DATA_BYTES-1:0]   upd_en;
    logic                    stall;
    logic [31:0]             lfsr_upd;
    logic [CNT_WIDTH:0]      n_bytes, cnt_sum;
    logic                    eff_mode;

    // Feeding the bit-reversed byte MSB-first equals feeding the original byte LSB-first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    assign accept = s_valid & s_ready;

    // Keep only matters on the last beat; earlier beats are always full.
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane_en
        assign in_en[gi] = s_last ? s_keep[gi] : 1'b1;
    end

`ifdef CRC32_STREAM_PIPE_EN
    logic                    p_acc_q, p_acc_d;
    logic                    p_last_q, p_last_d;
    logic                    p_mode_q, p_mode_d;
    logic [8*DATA_BYTES-1:0] p_data_q, p_data_d;
    logic [DATA_BYTES-1:0]   p_en_q, p_en_d;

    always_comb begin
        p_acc_d  = accept;
        p_last_d = p_last_q;
        p_mode_d = p_mode_q;
        p_data_d = p_data_q;
        p_en_d   = p_en_q;
        if (accept) begin
            p_last_d = s_last;
            p_mode_d = chk_mode;
            p_data_d = s_data;
            p_en_d   = in_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_acc_q  <= 1'b0;
            p_last_q <= 1'b0;
            p_mode_q <= 1'b0;
            p_data_q <= '0;
            p_en_q   <= '0;
        end else begin
            p_acc_q  <= p_acc_d;
            p_last_q <= p_last_d;
            p_mode_q <= p_mode_d;
            p_data_q <= p_data_d;
            p_en_q   <= p_en_d;
        end
    end

    assign upd_valid = p_acc_q;
    assign upd_last  = p_last_q;
    assign upd_mode  = p_mode_q;
    assign upd_data  = p_data_q;
    assign upd_en    = p_en_q;
    // Block input while the registered last beat closes the frame.
    assign stall     = p_acc_q & p_last_q;
`else
    assign upd_valid = accept;
    assign upd_last  = s_last;
    assign upd_mode  = chk_mode;
    assign upd_data  = s_data;
    assign upd_en    = in_en;
    assign stall     = 1'b0;
`endif

    // Lane cascade: lanes 0..n-1 applied in wire order within one cycle.
    always_comb begin
        lfsr_upd = lfsr_q;
        n_bytes  = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (upd_en[i]) begin
                lfsr_upd = crc_byte(lfsr_upd, upd_data[8*i +: 8]);
                n_bytes  = n_bytes + (CNT_WIDTH+1)'(1);
            end
        end
        cnt_sum = {1'b0, cnt_q} + n_bytes;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (upd_valid) state_d = upd_last ? RESULT : BUSY;
            BUSY:    if (upd_valid && upd_last) state_d = RESULT;
            RESULT:  if (crc_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_ready   = 1'b0;
        crc_valid = 1'b0;
        case (state_q)
            IDLE, BUSY: s_ready   = ~stall;
            RESULT:     crc_valid = 1'b1;
            default:    ;
        endcase
    end

    always_comb begin
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        crc_out_d = crc_out_q;
        crc_err_d = crc_err_q;
        // The first beat of a frame carries the mode for the whole frame.
        eff_mode  = (state_q == IDLE) ? upd_mode : mode_q;
        if (state_q == RESULT) begin
            if (crc_ready) begin
                lfsr_d = INIT;
                cnt_d  = '0;
            end
        end else if (upd_valid) begin
            lfsr_d = lfsr_upd;
            cnt_d  = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
            mode_d = eff_mode;
            if (upd_last) begin
                crc_out_d = ~bitrev32(lfsr_upd);
                crc_err_d = eff_mode & (lfsr_upd != RESIDUE);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q    <= INIT;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            crc_out_q <= '0;
            crc_err_q <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            crc_out_q <= crc_out_d;
            crc_err_q <= crc_err_d;
        end
    end

    assign crc_out  = crc_out_q;
    assign crc_err  = crc_err_q;
    assign byte_cnt = cnt_q;

endmodule

// File: tb/tb_crc32_stream.sv
// Bench for crc32_stream: a 4-lane/16-bit-count instance (A) and a 1-lane/4-bit-count instance (B),
// checked every cycle against a reflected byte-wise CRC-32 model plus literal expectations.
`timescale 1ns/1ps
module tb_crc32_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic        a_s_valid, a_s_ready, a_s_last, a_chk_mode, a_crc_valid, a_crc_ready, a_crc_err;
    logic [31:0] a_s_data, a_crc_out;
    logic [3:0]  a_s_keep;
    logic [15:0] a_byte_cnt;

    logic        b_s_valid, b_s_ready, b_s_last, b_chk_mode, b_crc_valid, b_crc_ready, b_crc_err;
    logic [7:0]  b_s_data;
    logic [0:0]  b_s_keep;
    logic [31:0] b_crc_out;
    logic [3:0]  b_byte_cnt;

    crc32_stream #(.DATA_BYTES(4), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .s_keep(a_s_keep), .s_last(a_s_last), .chk_mode(a_chk_mode), .crc_valid(a_crc_valid),
        .crc_ready(a_crc_ready), .crc_out(a_crc_out), .crc_err(a_crc_err), .byte_cnt(a_byte_cnt));

    crc32_stream #(.DATA_BYTES(1), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .s_keep(b_s_keep), .s_last(b_s_last), .chk_mode(b_chk_mode), .crc_valid(b_crc_valid),
        .crc_ready(b_crc_ready), .crc_out(b_crc_out), .crc_err(b_crc_err), .byte_cnt(b_byte_cnt));

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Textbook reflected CRC-32 (poly 0xEDB88320), one byte at a time.
    function automatic logic [31:0] ref_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // Model state per instance (0 = A, 1 = B)
    bit          m_pend[2];
    bit          m_in_frame[2];
    bit          m_mode[2];
    logic [31:0] m_crc[2];
    int          m_cnt[2];
    logic [31:0] m_exp_crc[2];
    logic        m_exp_err[2];
    int          m_exp_cnt[2];

    logic        c_rdy, c_vld, c_err, c_sv, c_sl, c_cm, c_cr;
    logic [31:0] c_co, c_d, c_bc;
    logic [3:0]  c_kp;
    int          c_lanes, c_cmax;
    string       c_nm;

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (k == 0) begin
                    c_nm = "A"; c_rdy = a_s_ready; c_vld = a_crc_valid; c_err = a_crc_err;
                    c_co = a_crc_out; c_bc = 32'(a_byte_cnt); c_sv = a_s_valid; c_sl = a_s_last;
                    c_cm = a_chk_mode; c_cr = a_crc_ready; c_d = a_s_data; c_kp = a_s_keep;
                    c_lanes = 4; c_cmax = 65535;
                end else begin
                    c_nm = "B"; c_rdy = b_s_ready; c_vld = b_crc_valid; c_err = b_crc_err;
                    c_co = b_crc_out; c_bc = 32'(b_byte_cnt); c_sv = b_s_valid; c_sl = b_s_last;
                    c_cm = b_chk_mode; c_cr = b_crc_ready; c_d = {24'h0, b_s_data}; c_kp = {3'b0, b_s_keep};
                    c_lanes = 1; c_cmax = 15;
                end
                if (!rst_n) begin
                    m_pend[k] = 0;
                    m_in_frame[k] = 0;
                    chk({c_nm, " rst s_ready"}, 32'(c_rdy), 32'd1);
                    chk({c_nm, " rst crc_valid"}, 32'(c_vld), 32'd0);
                    chk({c_nm, " rst crc_out"}, c_co, 32'd0);
                    chk({c_nm, " rst crc_err"}, 32'(c_err), 32'd0);
                    chk({c_nm, " rst byte_cnt"}, c_bc, 32'd0);
                end else begin
                    chk({c_nm, " s_ready"}, 32'(c_rdy), 32'(!m_pend[k]));
                    chk({c_nm, " crc_valid"}, 32'(c_vld), 32'(m_pend[k]));
                    if (m_pend[k]) begin
                        chk({c_nm, " crc_out"}, c_co, m_exp_crc[k]);
                        chk({c_nm, " crc_err"}, 32'(c_err), 32'(m_exp_err[k]));
                        chk({c_nm, " byte_cnt"}, c_bc, 32'(m_exp_cnt[k]));
                    end
                    // Advance the model by what the coming edge will do.
                    if (m_pend[k]) begin
                        if (c_cr) m_pend[k] = 0;
                    end else if (c_sv) begin
                        if (!m_in_frame[k]) begin
                            m_in_frame[k] = 1;
                            m_mode[k] = c_cm;
                            m_crc[k] = 32'hFFFF_FFFF;
                            m_cnt[k] = 0;
                        end
                        for (int l = 0; l < c_lanes; l++) begin
                            if (!c_sl || c_kp[l]) begin
                                m_crc[k] = ref_byte(m_crc[k], c_d[8*l +: 8]);
                                m_cnt[k]++;
                            end
                        end
                        if (c_sl) begin
                            m_in_frame[k] = 0;
                            m_pend[k] = 1;
                            m_exp_crc[k] = ~m_crc[k];
                            m_exp_err[k] = m_mode[k] && (~m_crc[k] != 32'h2144_DF1C);
                            m_exp_cnt[k] = (m_cnt[k] > c_cmax) ? c_cmax : m_cnt[k];
                        end
                    end
                end
            end
        end
    end

    task automatic a_beat(input logic [31:0] d, input logic [3:0] kp, input logic last, input logic mode);
        a_s_valid = 1; a_s_data = d; a_s_keep = kp; a_s_last = last; a_chk_mode = mode;
        @(posedge clk); #1;
        a_s_valid = 0;
    endtask

    task automatic b_beat(input logic [7:0] d, input logic last);
        b_s_valid = 1; b_s_data = d; b_s_keep = 1'b1; b_s_last = last; b_chk_mode = 0;
        @(posedge clk); #1;
        b_s_valid = 0;
    endtask

    function automatic logic cur_valid(input int k);
        return (k == 0) ? a_crc_valid : b_crc_valid;
    endfunction

    // Wait (bounded) for the result, pin it against literals, then consume it.
    task automatic take_result(input int k, input logic [31:0] ec, input bit use_c,
                               input logic ee, input logic [15:0] en, input string tag);
        int n;
        n = 0;
        while (cur_valid(k) !== 1'b1 && n < 6) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " result valid"}, 32'(cur_valid(k)), 32'd1);
        if (k == 0) begin
            if (use_c) chk({tag, " lit crc"}, a_crc_out, ec);
            chk({tag, " lit err"}, 32'(a_crc_err), 32'(ee));
            chk({tag, " lit cnt"}, 32'(a_byte_cnt), 32'(en));
            a_crc_ready = 1; @(posedge clk); #1; a_crc_ready = 0;
        end else begin
            if (use_c) chk({tag, " lit crc"}, b_crc_out, ec);
            chk({tag, " lit err"}, 32'(b_crc_err), 32'(ee));
            chk({tag, " lit cnt"}, 32'(b_byte_cnt), 32'(en));
            b_crc_ready = 1; @(posedge clk); #1; b_crc_ready = 0;
        end
    endtask

    logic [7:0] s9 [9];

    initial begin
        a_s_valid = 0; a_s_data = '0; a_s_keep = '0; a_s_last = 0; a_chk_mode = 0; a_crc_ready = 0;
        b_s_valid = 0; b_s_data = '0; b_s_keep = '0; b_s_last = 0; b_chk_mode = 0; b_crc_ready = 0;
        for (int i = 0; i < 9; i++) s9[i] = 8'h31 + 8'(i);
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // B: single lane "123456789"
        for (int i = 0; i < 9; i++) b_beat(s9[i], i == 8);
        take_result(1, 32'hCBF4_3926, 1, 0, 16'd9, "B 123456789");

        // B: reset mid-frame after 5 bytes, then full frame
        for (int i = 0; i < 5; i++) b_beat(s9[i], 0);
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 9; i++) b_beat(s9[i], i == 8);
        take_result(1, 32'hCBF4_3926, 1, 0, 16'd9, "B after reset");

        // B: 20 bytes, 4-bit counter saturates
        for (int i = 0; i < 20; i++) b_beat(8'(i * 7 + 3), i == 19);
        take_result(1, 32'h0, 0, 0, 16'd15, "B saturate");

        // A: "123456789" with an idle gap and garbage in unkept lanes
        a_beat(32'h3433_3231, 4'hF, 0, 0);
        @(posedge clk); #1;
        a_beat(32'h3837_3635, 4'hF, 0, 0);
        a_beat(32'hDEAD_BE39, 4'h1, 1, 0);
        take_result(0, 32'hCBF4_3926, 1, 0, 16'd9, "A 123456789");

        // A: check mode with good FCS; mode only sampled on the first beat
        a_beat(32'h3433_3231, 4'hF, 0, 1);
        a_beat(32'h3837_3635, 4'hF, 0, 0);
        a_beat(32'hF439_2639, 4'hF, 0, 0);
        a_beat(32'h5555_55CB, 4'h1, 1, 0);
        take_result(0, 32'h2144_DF1C, 1, 0, 16'd13, "A check good");

        // A: check mode with corrupted byte
        a_beat(32'h3433_3231, 4'hF, 0, 1);
        a_beat(32'h3837_3636, 4'hF, 0, 1);
        a_beat(32'hF439_2639, 4'hF, 0, 1);
        a_beat(32'h0000_00CB, 4'h1, 1, 1);
        take_result(0, 32'h0, 0, 1, 16'd13, "A check bad");

        // A: same good stream in generate mode never flags an error
        a_beat(32'h3433_3231, 4'hF, 0, 0);
        a_beat(32'h3837_3635, 4'hF, 0, 1);
        a_beat(32'hF439_2639, 4'hF, 0, 1);
        a_beat(32'h0000_00CB, 4'h1, 1, 1);
        take_result(0, 32'h2144_DF1C, 1, 0, 16'd13, "A gen residue");

        // A: empty last beat
        a_beat(32'h3433_3231, 4'hF, 0, 0);
        a_beat(32'hFFFF_FFFF, 4'h0, 1, 0);
        take_result(0, 32'h9BE3_E0A3, 1, 0, 16'd4, "A empty last");

        // A: single-beat frame
        a_beat(32'h3433_3231, 4'hF, 1, 0);
        take_result(0, 32'h9BE3_E0A3, 1, 0, 16'd4, "A one beat");

        // A: backpressure on the result with the next frame waiting on the input
        a_beat(32'h3837_3635, 4'hF, 1, 0);
        a_s_valid = 1; a_s_data = 32'h3433_3231; a_s_keep = 4'hF; a_s_last = 0; a_chk_mode = 0;
        repeat (3) begin
            chk("A bp s_ready", 32'(a_s_ready), 32'd0);
            chk("A bp crc_valid", 32'(a_crc_valid), 32'd1);
            @(posedge clk); #1;
        end
        a_crc_ready = 1; @(posedge clk); #1; a_crc_ready = 0;
        @(posedge clk); #1;
        a_beat(32'h3837_3635, 4'hF, 0, 0);
        a_beat(32'h0000_0039, 4'h1, 1, 0);
        take_result(0, 32'hCBF4_3926, 1, 0, 16'd9, "A after bp");

        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
